// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding, parity selectors and legal oversampling ratios.
package uart_pkg;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PRESC_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [PRESC_W-1:0] PRESC_8  = PRESC_W'(8);
    localparam logic [PRESC_W-1:0] PRESC_16 = PRESC_W'(16);
    localparam logic [PRESC_W-1:0] PRESC_32 = PRESC_W'(32);

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing: counts oversampling ticks, takes three mid-bit samples and
// reports the majority value plus the sample-ready and end-of-bit strobes.
module uart_rx_sampler #(
    parameter int unsigned presc_w = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_rx_s,
    input  logic [presc_w-1:0] i_presc,
    output logic               o_bit_c,
    output logic               o_sample_done_c,
    output logic               o_bit_done_c
);

    logic [presc_w-1:0] r_edge_cnt;
    logic [presc_w-1:0] w_half;
    logic [presc_w-1:0] w_last;
    logic               r_s0;
    logic               r_s1;
    logic               r_s2;

    assign w_half = i_presc >> 1;
    assign w_last = i_presc - presc_w'(1);

    // Wrap at Prescale-1 so an illegal ratio still cycles rather than sticking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
        end else begin
            if (!i_run) begin
                r_edge_cnt <= '0;
            end else if (r_edge_cnt == w_last) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + presc_w'(1);
            end
            if (r_edge_cnt == (w_half - presc_w'(1))) r_s0 <= i_rx_s;
            if (r_edge_cnt == w_half)                 r_s1 <= i_rx_s;
            if (r_edge_cnt == (w_half + presc_w'(1))) r_s2 <= i_rx_s;
        end
    end

    assign o_bit_c         = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
    assign o_sample_done_c = (r_edge_cnt == (w_half + presc_w'(2)));
    assign o_bit_done_c    = (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver front-end: synchronizes RX, deframes start/data/parity/stop
// and emits one byte per good frame with a single-cycle valid pulse.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned width   = WIDTH,
    parameter int unsigned presc_w = PRESC_W
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               RX_IN,
    input  logic [presc_w-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [width-1:0]   P_DATA,
    output logic               Data_Valid,
    output logic               Parity_Error,
    output logic               Stop_Error
);

    localparam int unsigned BIT_CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(width - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic                   r_sync1;
    logic                   r_rx_s;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
    logic [width-1:0]       r_shift;
    logic [width-1:0]       w_shift_nxt;
    logic                   r_par_bad;
    logic                   w_par_bad_nxt;
    logic [presc_w-1:0]     r_presc;
    logic [presc_w-1:0]     w_presc_nxt;
    logic                   r_par_en;
    logic                   w_par_en_nxt;
    logic                   r_par_typ;
    logic                   w_par_typ_nxt;
    logic [width-1:0]       r_p_data;
    logic [width-1:0]       w_p_data_nxt;
    logic                   r_dv;
    logic                   w_dv_nxt;
    logic                   r_par_err;
    logic                   w_par_err_nxt;
    logic                   r_stop_err;
    logic                   w_stop_err_nxt;
    logic                   w_frame_start;
    logic [presc_w-1:0]     w_presc_s;
    logic                   w_run;
    logic                   w_bit;
    logic                   w_sample_done;
    logic                   w_bit_done;

    // Live ratio while idle so the detection cycle already counts as tick 0.
    assign w_presc_s = (r_state == IDLE) ? Prescale : r_presc;
    assign w_run     = (w_state_nxt != IDLE);

    uart_rx_sampler #(
        .presc_w (presc_w)
    ) u_sampler (
        .i_clk           (CLK),
        .i_rst_n         (Reset),
        .i_run           (w_run),
        .i_rx_s          (r_rx_s),
        .i_presc         (w_presc_s),
        .o_bit_c         (w_bit),
        .o_sample_done_c (w_sample_done),
        .o_bit_done_c    (w_bit_done)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_bad_nxt  = r_par_bad;
        w_presc_nxt    = r_presc;
        w_par_en_nxt   = r_par_en;
        w_par_typ_nxt  = r_par_typ;
        w_p_data_nxt   = r_p_data;
        w_dv_nxt       = 1'b0;
        w_par_err_nxt  = r_par_err;
        w_stop_err_nxt = r_stop_err;
        w_frame_start  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt   = START;
                    w_frame_start = 1'b1;
                end
            end
            START: begin
                if (w_sample_done && w_bit) begin
                    w_state_nxt = IDLE;
                end else if (w_bit_done) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_sample_done) w_shift_nxt[r_bit_cnt] = w_bit;
                if (w_bit_done) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_sample_done) begin
                    w_par_bad_nxt = (w_bit != ((^r_shift) ^ (r_par_typ == PAR_ODD)));
                end
                if (w_bit_done) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_bit_done) begin
                    w_par_err_nxt  = r_par_bad;
                    w_stop_err_nxt = !w_bit;
                    if (w_bit && !r_par_bad) begin
                        w_p_data_nxt = r_shift;
                        w_dv_nxt     = 1'b1;
                    end
                    // A line already low here is the next frame's start bit.
                    if (!r_rx_s) begin
                        w_state_nxt   = START;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_frame_start) begin
            w_presc_nxt   = Prescale;
            w_par_en_nxt  = PAR_EN;
            w_par_typ_nxt = PAR_TYP;
            w_bit_cnt_nxt = '0;
            w_par_bad_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_presc    <= PRESC_8;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_p_data   <= '0;
            r_dv       <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bad  <= w_par_bad_nxt;
            r_presc    <= w_presc_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_typ  <= w_par_typ_nxt;
            r_p_data   <= w_p_data_nxt;
            r_dv       <= w_dv_nxt;
            r_par_err  <= w_par_err_nxt;
            r_stop_err <= w_stop_err_nxt;
        end
    end

    assign P_DATA       = r_p_data;
    assign Data_Valid   = r_dv;
    assign Parity_Error = r_par_err;
    assign Stop_Error   = r_stop_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: parity/stop errors, glitch rejection,
// back-to-back frames and mid-frame reset, with hand-computed expectations.
module tb_uart_rx_frame;
    import uart_pkg::*;

    logic       CLK;
    logic       Reset;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    bit         dv_prev = 1'b0;
    bit         dv_double = 1'b0;

    uart_rx_frame #(
        .width   (8),
        .presc_w (6)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every valid pulse with its cycle and byte.
    always @(negedge CLK) begin
        if (Data_Valid === 1'b1) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(P_DATA);
            if (dv_prev) dv_double = 1'b1;
        end
        dv_prev = (Data_Valid === 1'b1);
    end

    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input int p);
        last_start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pb, p);
        drive_bit(sb, p);
    endtask

    task automatic settle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; RX_IN = 1'b1; Prescale = PRESC_8; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        #2 Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL reset_pdata got=%h want=00", P_DATA); end
        total++; if (Data_Valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", Data_Valid); end
        total++; if (Parity_Error !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", Parity_Error); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL reset_serr got=%b want=0", Stop_Error); end
        Reset = 1'b1;
        settle(5);
    endtask

    task automatic test_even_parity;
        int n0;
        Prescale = PRESC_8; PAR_EN = 1'b1; PAR_TYP = PAR_EVEN;
        n0 = dv_cyc_q.size();
        send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 8);
        settle(6);
        total++;
        if (dv_cyc_q.size() !== n0 + 1) begin
            bad++; $display("FAIL even_dv_count got=%0d want=%0d", dv_cyc_q.size() - n0, 1);
        end else begin
            total++; if (dv_dat_q[n0] !== 8'hAA) begin bad++; $display("FAIL even_dv_data got=%h want=aa", dv_dat_q[n0]); end
            total++;
            if (dv_cyc_q[n0] - last_start_cyc !== 90) begin
                bad++; $display("FAIL even_latency got=%0d want=90", dv_cyc_q[n0] - last_start_cyc);
            end
        end
        total++; if (P_DATA !== 8'hAA) begin bad++; $display("FAIL even_pdata got=%h want=aa", P_DATA); end
        total++; if (Parity_Error !== 1'b0) begin bad++; $display("FAIL even_perr got=%b want=0", Parity_Error); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL even_serr got=%b want=0", Stop_Error); end
    endtask

    task automatic test_parity_error;
        int n0;
        Prescale = PRESC_16; PAR_EN = 1'b1; PAR_TYP = PAR_ODD;
        n0 = dv_cyc_q.size();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        settle(8);
        total++; if (Parity_Error !== 1'b1) begin bad++; $display("FAIL par_perr got=%b want=1", Parity_Error); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL par_serr got=%b want=0", Stop_Error); end
        total++; if (dv_cyc_q.size() !== n0) begin bad++; $display("FAIL par_dv_count got=%0d want=0", dv_cyc_q.size() - n0); end
        total++; if (P_DATA !== 8'hAA) begin bad++; $display("FAIL par_pdata got=%h want=aa", P_DATA); end
    endtask

    task automatic test_stop_error;
        int n0;
        Prescale = PRESC_32; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        n0 = dv_cyc_q.size();
        send_frame(8'hDD, 1'b0, 1'b0, 1'b0, 32);
        settle(40);
        total++; if (Stop_Error !== 1'b1) begin bad++; $display("FAIL stop_serr got=%b want=1", Stop_Error); end
        total++; if (Parity_Error !== 1'b0) begin bad++; $display("FAIL stop_perr got=%b want=0", Parity_Error); end
        total++; if (dv_cyc_q.size() !== n0) begin bad++; $display("FAIL stop_dv_count got=%0d want=0", dv_cyc_q.size() - n0); end
        total++; if (P_DATA !== 8'hAA) begin bad++; $display("FAIL stop_pdata got=%h want=aa", P_DATA); end
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 32);
        settle(6);
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL clear_serr got=%b want=0", Stop_Error); end
        total++; if (Parity_Error !== 1'b0) begin bad++; $display("FAIL clear_perr got=%b want=0", Parity_Error); end
        total++; if (P_DATA !== 8'h01) begin bad++; $display("FAIL clear_pdata got=%h want=01", P_DATA); end
        total++; if (dv_cyc_q.size() !== n0 + 1) begin bad++; $display("FAIL clear_dv_count got=%0d want=1", dv_cyc_q.size() - n0); end
    endtask

    task automatic test_glitch;
        int n0;
        Prescale = PRESC_8; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        n0 = dv_cyc_q.size();
        drive_bit(1'b0, 3);
        settle(20);
        total++; if (dv_cyc_q.size() !== n0) begin bad++; $display("FAIL glitch_dv_count got=%0d want=0", dv_cyc_q.size() - n0); end
        total++; if (P_DATA !== 8'h01) begin bad++; $display("FAIL glitch_pdata got=%h want=01", P_DATA); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL glitch_serr got=%b want=0", Stop_Error); end
        send_frame(8'hBB, 1'b0, 1'b0, 1'b1, 8);
        settle(6);
        total++; if (P_DATA !== 8'hBB) begin bad++; $display("FAIL glitch_next_pdata got=%h want=bb", P_DATA); end
        total++; if (dv_cyc_q.size() !== n0 + 1) begin bad++; $display("FAIL glitch_next_dv got=%0d want=1", dv_cyc_q.size() - n0); end
    endtask

    task automatic test_back_to_back;
        int         n0;
        int         s0;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hCC; exp_b[1] = 8'h05; exp_b[2] = 8'h02;
        Prescale = PRESC_8; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        n0 = dv_cyc_q.size();
        s0 = cyc;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b0, 1'b0, 1'b1, 8);
        settle(6);
        total++;
        if (dv_cyc_q.size() !== n0 + 3) begin
            bad++; $display("FAIL b2b_dv_count got=%0d want=3", dv_cyc_q.size() - n0);
        end else begin
            total++;
            if (dv_cyc_q[n0] - s0 !== 82) begin
                bad++; $display("FAIL b2b_first_latency got=%0d want=82", dv_cyc_q[n0] - s0);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (dv_dat_q[n0 + i] !== exp_b[i]) begin
                    bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, dv_dat_q[n0 + i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (dv_cyc_q[n0 + i] - dv_cyc_q[n0 + i - 1] !== 80) begin
                    bad++; $display("FAIL b2b_gap%0d got=%0d want=80", i, dv_cyc_q[n0 + i] - dv_cyc_q[n0 + i - 1]);
                end
            end
        end
        total++; if (dv_double !== 1'b0) begin bad++; $display("FAIL dv_double got=%b want=0", dv_double); end
    endtask

    task automatic test_reset_mid_frame;
        int         n0;
        logic [7:0] d;
        d = 8'h7E;
        Prescale = PRESC_8; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        n0 = dv_cyc_q.size();
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
        RX_IN = d[4];
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        #2;
        total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL rst_mid_pdata got=%h want=00", P_DATA); end
        total++; if (Data_Valid !== 1'b0) begin bad++; $display("FAIL rst_mid_dv got=%b want=0", Data_Valid); end
        total++; if (Parity_Error !== 1'b0) begin bad++; $display("FAIL rst_mid_perr got=%b want=0", Parity_Error); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL rst_mid_serr got=%b want=0", Stop_Error); end
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b1;
        settle(20);
        total++; if (dv_cyc_q.size() !== n0) begin bad++; $display("FAIL rst_mid_partial_dv got=%0d want=0", dv_cyc_q.size() - n0); end
        send_frame(d, 1'b0, 1'b0, 1'b1, 8);
        settle(6);
        total++; if (P_DATA !== 8'h7E) begin bad++; $display("FAIL rst_mid_next_pdata got=%h want=7e", P_DATA); end
        total++; if (dv_cyc_q.size() !== n0 + 1) begin bad++; $display("FAIL rst_mid_next_dv got=%0d want=1", dv_cyc_q.size() - n0); end
        total++; if (Stop_Error !== 1'b0) begin bad++; $display("FAIL rst_mid_next_serr got=%b want=0", Stop_Error); end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial UART receiver front-end. It oversamples the RX line, deframes start/data/parity/stop bits, and delivers one parallel byte per frame as a single-cycle valid pulse. It sits directly upstream of the system receive controller: P_DATA and Data_Valid drive that controller's Rx_P_Data and RxValid inputs.

Parameters:
width, 8, data bits per frame (LSB first)
presc_w, 6, width of the Prescale input

Ports:
CLK  in  1  oversampling clock (Prescale x baud)
Reset  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high, asynchronous to CLK
Prescale  in  presc_w  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = parity bit present in frame
PAR_TYP  in  1  0 = even parity, 1 = odd parity
P_DATA  out  width  received byte; held until the next good frame
Data_Valid  out  1  one-cycle pulse, P_DATA valid
Parity_Error  out  1  high when the last frame's parity mismatched
Stop_Error  out  1  high when the last frame's stop bit sampled 0

Behaviour:
- One clock. Reset is asynchronous and active-low: CLK, Reset as named. Already decided.
- Reset values: P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0, FSM=IDLE, all counters 0. Synchronizer flops reset to 1 (line idle).
- RX_IN passes through a 2-flop synchronizer (rx_s). All logic below uses rx_s, so there is 2 cycles of input latency.
- Prescale, PAR_EN and PAR_TYP are latched when leaving IDLE. Changes mid-frame have no effect. Illegal Prescale values give undefined results but must not lock up the FSM.
- Counters:
  - edge_cnt: 0..Prescale-1, counts cycles within one bit.
  - bit_cnt: 0..width-1, counts data bits.
- Bit sampling: majority of 3 samples of rx_s taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is available from edge_cnt = Prescale/2+2.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, with edge_cnt cleared.
  - START: at the sampled value, bit==1 means a glitch -> IDLE with no outputs touched. At edge_cnt==Prescale-1 -> DATA.
  - DATA: shift the sampled bit into the shift register at bit position bit_cnt (LSB first). At edge_cnt==Prescale-1 with bit_cnt==width-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: compare the sampled bit with the XOR of the data bits (inverted when PAR_TYP=1). At edge_cnt==Prescale-1 -> STOP.
  - STOP: at edge_cnt==Prescale-1, evaluate the frame:
    - If the stop bit==1 and there is no parity error: P_DATA <= shift register and Data_Valid=1 in the next cycle, for exactly 1 cycle.
    - Parity_Error and Stop_Error are registered at the same instant.
    - Next state: IDLE, or START directly if rx_s==0 (back-to-back frames with no idle gap).
- Error flags are held until the next frame's stop evaluation. A bad frame never pulses Data_Valid and leaves P_DATA unchanged.
- Frame length: (1 + width + PAR_EN + 1) x Prescale cycles. Data_Valid rises 3 cycles after the final stop-bit cycle seen at RX_IN (2 synchronizer cycles + 1 register cycle).
- Reset asserted mid-frame: immediate return to IDLE and the partial byte is discarded. After release, the block waits for a fresh falling edge. A line that is held low on release is treated as a start bit.
- Data_Valid is never high on two consecutive cycles.

Decomposition:
- Shared package (uart_pkg):
  - state encoding localparams IDLE/START/DATA/PARITY/STOP
  - PAR_EVEN / PAR_ODD constants
  - legal prescale constants PRESC_8 / 16 / 32
- One natural sub-module, uart_rx_sampler: edge_cnt, the 3-sample majority vote and a bit_done strobe (edge_cnt==Prescale-1). The FSM, bit_cnt, shift register, parity check and output registers stay in the top module.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0; send 0xAA with parity 0 and stop 1 -> P_DATA=0xAA, exactly one Data_Valid pulse, errors 0, 88-cycle frame.
- Prescale=16, PAR_EN=1, PAR_TYP=1; send 0x3C with wrong parity bit 0 -> Parity_Error=1, no Data_Valid, P_DATA keeps its previous value.
- Prescale=32, PAR_EN=0; send 0xDD with stop bit 0 -> Stop_Error=1, no Data_Valid. The next good frame 0x01 clears both flags.
- Glitch: RX_IN low for 3 cycles at Prescale=8 -> FSM returns to IDLE, no output change; the following 0xBB frame is received correctly.
- Back-to-back frames 0xCC, 0x05, 0x02 with no idle gap, Prescale=8, PAR_EN=0 -> three Data_Valid pulses 80 cycles apart with the correct bytes.
- Reset pulsed low during data bit 4 of a frame -> all outputs 0 immediately; the next full frame 0x7E is received correctly.
